mc_cu: RTL
==========

Name: mc_cu

Overview:
- Multicycle successor to the single-cycle MIPS control unit: same instruction subset, now executed as a state machine over several clock cycles.
- The datapath shares one ALU and one memory port.
- Adds an optional memory ready handshake with a timeout, illegal-opcode detection and a visible state output.
- Sits between the instruction register (op/func fields), the ALU zero flag and the multicycle datapath / memory.

Parameters:
- MEM_HANDSHAKE, 0: 1 = IF and MEM stall until mem_ready=1; 0 = mem_ready is ignored and each memory access takes 1 cycle.
- WAIT_LIMIT, 0: maximum stall cycles per access before bus_err; 0 = no timeout. Used only when MEM_HANDSHAKE=1.
- CNT_W, 8: width of the stall counter; WAIT_LIMIT < 2**CNT_W.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  instruction[31:26], taken from the instruction register
- func  in  6  instruction[5:0]
- z  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- wmem  out  1  memory write request
- wreg  out  1  register file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALU-out register
- regrt  out  1  destination register: 1 = rt, 0 = rd
- m2reg  out  1  write-back data: 1 = MDR, 0 = ALU-out
- aluc  out  4  ALU operation
- shift  out  1  ALU A input = sa
- alusrca  out  1  0 = PC, 1 = register A (or sa when shift=1)
- alusrcb  out  2  00 = register B, 01 = constant 4, 10 = extended immediate, 11 = sign-extended immediate << 2
- pcsource  out  2  00 = ALU result, 01 = ALU-out register (branch target), 10 = register A (jr), 11 = jump target
- jal  out  1  write PC to $31
- sext  out  1  immediate sign-extend (0 = zero-extend)
- illegal  out  1  1-cycle pulse on an unsupported instruction
- bus_err  out  1  1-cycle pulse on a memory timeout
- state  out  3  current state, for debug

Behaviour:
- Instruction set: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal. Any other op/func combination is illegal.
- aluc codes: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
- sext = 1 for addi, lw, sw, beq, bne. regrt = 1 for all I-type instructions that write a register.
- States: IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4. A registered state drives all outputs, which are decoded combinationally from state, op, func, z, mem_ready and the stall counter.
- In every state, any output not named below is 0 (aluc = 0000, alusrcb = 00, pcsource = 00).
- Reset: on reset=1, state goes to IF and the stall counter clears. While reset is high, every write enable, illegal and bus_err are forced to 0. Reset asserted mid-instruction abandons the instruction with no further writes.
- IF:
  - Drives iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - If not stalled: wpc=1, wir=1, go to ID.
  - Stalled means MEM_HANDSHAKE=1 and mem_ready=0: wpc=0, wir=0, stay in IF.
- ID:
  - Drives alusrca=0, alusrcb=11, aluc=add (branch target latched into ALU-out).
  - j: wpc=1, pcsource=11, go to IF.
  - jal: as j, plus wreg=1, jal=1.
  - jr: wpc=1, pcsource=10, go to IF.
  - illegal: illegal=1, no writes, go to IF.
  - Otherwise go to EXE.
- EXE:
  - Drives alusrca=1 and the instruction's aluc.
  - alusrcb=10 for immediate instructions and lw/sw (aluc=add for lw/sw); 00 otherwise. shift=1 for sll/srl/sra.
  - beq/bne: aluc=sub, alusrcb=00. wpc=1 with pcsource=01 when (beq & z) | (bne & ~z). Go to IF.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - Drives iord=1; wmem=1 for sw, held for the whole stall.
  - If not stalled: sw goes to IF, lw goes to WB. If stalled: stay.
- WB:
  - wreg=1; m2reg=1 for lw; regrt as decoded. Go to IF.
- Stall counter:
  - Increments each stalled cycle in IF or MEM and clears on any state change.
  - If WAIT_LIMIT>0 and the counter equals WAIT_LIMIT while still stalled: bus_err=1 for that cycle, wmem forced 0, no PC/IR write, next state IF, counter cleared.
  - mem_ready=1 in the same cycle as the limit is reached counts as success, not an error.
- Cycle counts with no stalls:
  - j / jal / jr / illegal: 2
  - beq / bne: 3
  - sw and all ALU instructions: 4
  - lw: 5

Test Plan:
- Reset held 3 cycles, then released with MEM_HANDSHAKE=0 → state=0 and all enables 0 during reset; first cycle after release: wpc=1, wir=1.
- MEM_HANDSHAKE=0, run add (op=000000, func=100000), then lw (op=100011) → add: IF, ID, EXE, WB with wreg=1, regrt=0, aluc=0000. lw: 5 states; WB has m2reg=1, regrt=1; MEM has iord=1.
- beq with z=1, then beq with z=0, then bne with z=0 → wpc=1, pcsource=01 in EXE for the first and third; second returns to IF with wpc=0. Each takes 3 cycles.
- jal (op=000011) → in ID: wpc=1, wreg=1, jal=1, pcsource=11; next state IF; total 2 cycles.
- MEM_HANDSHAKE=1, WAIT_LIMIT=0, sw with mem_ready low for 3 MEM cycles → wmem=1 for 4 consecutive cycles, then IF. Same test with WAIT_LIMIT=2 → bus_err pulse on the 3rd stalled cycle, wmem=0 on that cycle, next state IF.
- op=111111 → illegal=1 for exactly 1 cycle in ID, no wpc/wreg/wmem, next instruction fetched normally.

Source files
------------

// File: rtl/mc_cu.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB state machine driving a shared-ALU,
// single-memory-port datapath, with optional memory handshake, stall timeout and illegal trap.
module mc_cu #(
    parameter bit          MEM_HANDSHAKE = 1'b0,
    parameter int unsigned WAIT_LIMIT    = 0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic [3:0] aluc,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       jal,
    output logic       sext,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StExe = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    logic legal, is_shift, is_imm, writes_rt, is_branch, br_taken;
    logic [3:0] exe_aluc;
    logic stalled, timeout;

    always_comb begin
        r_type = (op == 6'b000000);
        i_add  = r_type && (func == 6'b100000);
        i_sub  = r_type && (func == 6'b100010);
        i_and  = r_type && (func == 6'b100100);
        i_or   = r_type && (func == 6'b100101);
        i_xor  = r_type && (func == 6'b100110);
        i_sll  = r_type && (func == 6'b000000);
        i_srl  = r_type && (func == 6'b000010);
        i_sra  = r_type && (func == 6'b000011);
        i_jr   = r_type && (func == 6'b001000);
        i_addi = (op == 6'b001000);
        i_andi = (op == 6'b001100);
        i_ori  = (op == 6'b001101);
        i_xori = (op == 6'b001110);
        i_lw   = (op == 6'b100011);
        i_sw   = (op == 6'b101011);
        i_beq  = (op == 6'b000100);
        i_bne  = (op == 6'b000101);
        i_lui  = (op == 6'b001111);
        i_j    = (op == 6'b000010);
        i_jal  = (op == 6'b000011);

        legal = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq | i_bne |
                i_lui | i_j | i_jal;
        is_shift  = i_sll | i_srl | i_sra;
        writes_rt = i_addi | i_andi | i_ori | i_xori | i_lui | i_lw;
        is_imm    = writes_rt | i_sw;
        is_branch = i_beq | i_bne;
        br_taken  = (i_beq & z) | (i_bne & ~z);

        exe_aluc = 4'b0000;
        if (i_sub || is_branch)  exe_aluc = 4'b0100;
        else if (i_and || i_andi) exe_aluc = 4'b0001;
        else if (i_or || i_ori)   exe_aluc = 4'b0101;
        else if (i_xor || i_xori) exe_aluc = 4'b0010;
        else if (i_lui)           exe_aluc = 4'b0110;
        else if (i_sll)           exe_aluc = 4'b0011;
        else if (i_srl)           exe_aluc = 4'b0111;
        else if (i_sra)           exe_aluc = 4'b1111;
    end

    // Only memory-access states can stall, and only when the handshake is in use.
    always_comb begin
        stalled = MEM_HANDSHAKE && !mem_ready && (state_q == StIf || state_q == StMem);
        timeout = stalled && (WAIT_LIMIT != 0) && (cnt_q == CNT_W'(WAIT_LIMIT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIf;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIf: begin
                if (timeout)       state_d = StIf;
                else if (!stalled) state_d = StId;
            end
            StId: begin
                if (!legal || i_j || i_jal || i_jr) state_d = StIf;
                else                                state_d = StExe;
            end
            StExe: begin
                if (is_branch)         state_d = StIf;
                else if (i_lw || i_sw) state_d = StMem;
                else                   state_d = StWb;
            end
            StMem: begin
                if (timeout)       state_d = StIf;
                else if (!stalled) state_d = i_sw ? StIf : StWb;
            end
            StWb:    state_d = StIf;
            default: state_d = StIf;
        endcase
        cnt_d = (stalled && !timeout) ? cnt_q + 1'b1 : '0;
    end

    always_comb begin
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        aluc     = 4'b0000;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsource = 2'b00;
        jal      = 1'b0;
        sext     = 1'b0;
        illegal  = 1'b0;
        bus_err  = timeout;
        unique case (state_q)
            StIf: begin
                alusrcb = 2'b01;
                if (!stalled) begin
                    wpc = 1'b1;
                    wir = 1'b1;
                end
            end
            StId: begin
                // ALU precomputes the branch target while the instruction decodes.
                alusrcb = 2'b11;
                if (!legal) begin
                    illegal = 1'b1;
                end else if (i_j || i_jal) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                    wreg     = i_jal;
                    jal      = i_jal;
                end else if (i_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                end
            end
            StExe: begin
                alusrca = 1'b1;
                aluc    = exe_aluc;
                alusrcb = is_imm ? 2'b10 : 2'b00;
                shift   = is_shift;
                sext    = i_addi | i_lw | i_sw | is_branch;
                if (is_branch && br_taken) begin
                    wpc      = 1'b1;
                    pcsource = 2'b01;
                end
            end
            StMem: begin
                iord = 1'b1;
                wmem = i_sw && !timeout;
            end
            StWb: begin
                wreg  = 1'b1;
                m2reg = i_lw;
                regrt = writes_rt;
            end
            default: ;
        endcase
        if (reset) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wmem    = 1'b0;
            wreg    = 1'b0;
            illegal = 1'b0;
            bus_err = 1'b0;
        end
    end

    assign state = state_q;

endmodule
